// File: rtl/axi_rd_burst_scheduler_if.sv
// Burst command and read-beat handshake between the read burst scheduler
// and the AXI master. "master" is the scheduler side, "slave" is the AXI
// master / data path side that accepts commands and reports beats.
interface axi_rd_burst_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic                  cmd_src;
  logic                  rd_beat;
  logic                  rd_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_src,
    input  cmd_ready, rd_beat, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_src,
    output cmd_ready, rd_beat, rd_last
  );
endinterface

// File: rtl/axi_rd_burst_scheduler.sv
// Read burst scheduler for the CNN AXI master.
// Two fetch streams (0 = IFM, 1 = weights) share one read-address path.
// Each stream is cut into INCR bursts that stay inside a 4 KB page, a burst
// is only issued when the destination FIFO can absorb all of it, and the
// streams alternate round-robin with a single burst outstanding.
module axi_rd_burst_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_BYTES = 32,
  parameter int MAX_BURST  = 128,
  parameter int CNT_WIDTH  = 20,
  parameter int CRD_WIDTH  = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_ifm_base,
  input  logic [CNT_WIDTH-1:0]  cfg_ifm_beats,
  input  logic [ADDR_WIDTH-1:0] cfg_wgt_base,
  input  logic [CNT_WIDTH-1:0]  cfg_wgt_beats,
  input  logic [CRD_WIDTH-1:0]  ifm_credit,
  input  logic [CRD_WIDTH-1:0]  wgt_credit,
  axi_rd_burst_scheduler_if.master cmd_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state_r;
  logic [CNT_WIDTH-1:0]  rem_ifm_r;
  logic [CNT_WIDTH-1:0]  rem_wgt_r;
  logic [ADDR_WIDTH-1:0] addr_ifm_r;
  logic [ADDR_WIDTH-1:0] addr_wgt_r;
  logic                  last_grant_r;
  logic [8:0]            bb_r;
  logic [8:0]            beat_cnt_r;
  logic                  cmd_valid_r;
  logic [ADDR_WIDTH-1:0] cmd_addr_r;
  logic [7:0]            cmd_len_r;
  logic                  cmd_src_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;

  logic [8:0]            bb_ifm_s;
  logic [8:0]            bb_wgt_s;
  logic                  elig_ifm_s;
  logic                  elig_wgt_s;
  logic                  any_elig_s;
  logic                  grant_s;
  logic [8:0]            bb_sel_s;
  logic [8:0]            len_tmp_s;
  logic [7:0]            len_sel_s;
  logic [ADDR_WIDTH-1:0] addr_sel_s;

  // Largest legal burst from a page offset: limited by the remaining beats,
  // MAX_BURST, and the beats left before the next 4 KB boundary.
  function automatic logic [8:0] calc_bb(input logic [11:0] page_off,
                                         input logic [CNT_WIDTH-1:0] rem);
    logic [12:0]          room;
    logic [CNT_WIDTH-1:0] lim;
    room = (13'd4096 - {1'b0, page_off}) >> BEAT_SHIFT;
    lim  = CNT_WIDTH'(room);
    if (CNT_WIDTH'(MAX_BURST) < lim) begin
      lim = CNT_WIDTH'(MAX_BURST);
    end else begin
      lim = lim;
    end
    if (rem < lim) begin
      lim = rem;
    end else begin
      lim = lim;
    end
    return 9'(lim);
  endfunction

  // Burst sizing, credit eligibility and round-robin grant for the ARB state.
  always_comb begin
    bb_ifm_s   = calc_bb(addr_ifm_r[11:0], rem_ifm_r);
    bb_wgt_s   = calc_bb(addr_wgt_r[11:0], rem_wgt_r);
    elig_ifm_s = (rem_ifm_r != '0) && (32'(ifm_credit) >= 32'(bb_ifm_s));
    elig_wgt_s = (rem_wgt_r != '0) && (32'(wgt_credit) >= 32'(bb_wgt_s));
    any_elig_s = elig_ifm_s | elig_wgt_s;
    grant_s    = 1'b0;
    if (elig_ifm_s && elig_wgt_s) begin
      grant_s = ~last_grant_r;
    end else if (elig_wgt_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      bb_sel_s   = bb_wgt_s;
      addr_sel_s = addr_wgt_r;
    end else begin
      bb_sel_s   = bb_ifm_s;
      addr_sel_s = addr_ifm_r;
    end
    len_tmp_s = bb_sel_s - 9'd1;
    len_sel_s = len_tmp_s[7:0];
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r      <= ST_IDLE;
      rem_ifm_r    <= '0;
      rem_wgt_r    <= '0;
      addr_ifm_r   <= '0;
      addr_wgt_r   <= '0;
      last_grant_r <= 1'b0;
      bb_r         <= 9'd0;
      beat_cnt_r   <= 9'd0;
      cmd_valid_r  <= 1'b0;
      cmd_addr_r   <= '0;
      cmd_len_r    <= 8'd0;
      cmd_src_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (cfg_start) begin
            rem_ifm_r  <= cfg_ifm_beats;
            rem_wgt_r  <= cfg_wgt_beats;
            addr_ifm_r <= cfg_ifm_base;
            addr_wgt_r <= cfg_wgt_base;
            err_r      <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (any_elig_s) begin
            cmd_addr_r   <= addr_sel_s;
            cmd_len_r    <= len_sel_s;
            cmd_src_r    <= grant_s;
            bb_r         <= bb_sel_s;
            last_grant_r <= grant_s;
            cmd_valid_r  <= 1'b1;
            state_r      <= ST_ISSUE;
          end else if ((rem_ifm_r == '0) && (rem_wgt_r == '0)) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          // Remaining count and next address advance once the command is taken.
          if (cmd_bus.cmd_ready) begin
            cmd_valid_r <= 1'b0;
            beat_cnt_r  <= 9'd0;
            if (cmd_src_r) begin
              rem_wgt_r  <= rem_wgt_r - CNT_WIDTH'(bb_r);
              addr_wgt_r <= addr_wgt_r + (ADDR_WIDTH'(bb_r) << BEAT_SHIFT);
            end else begin
              rem_ifm_r  <= rem_ifm_r - CNT_WIDTH'(bb_r);
              addr_ifm_r <= addr_ifm_r + (ADDR_WIDTH'(bb_r) << BEAT_SHIFT);
            end
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // beat_cnt holds the beats seen before the current one; on RLAST it must equal len.
          if (cmd_bus.rd_beat) begin
            if (cmd_bus.rd_last) begin
              err_r   <= err_r | (beat_cnt_r != {1'b0, cmd_len_r});
              state_r <= ST_ARB;
            end else if (beat_cnt_r != 9'h1FF) begin
              beat_cnt_r <= beat_cnt_r + 9'd1;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          cmd_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_bus.cmd_valid = cmd_valid_r;
  assign cmd_bus.cmd_addr  = cmd_addr_r;
  assign cmd_bus.cmd_len   = cmd_len_r;
  assign cmd_bus.cmd_src   = cmd_src_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign err               = err_r;

endmodule

// File: tb/tb_axi_rd_burst_scheduler.sv
// Testbench for axi_rd_burst_scheduler: table of layer configurations with
// their expected burst commands, a scoreboard queue of pending commands, and
// hand-written sequences for credit wait, back-pressure, short bursts and reset.
module tb_axi_rd_burst_scheduler;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        src;
  } cmd_t;

  typedef struct {
    logic [31:0] ifm_base;
    logic [19:0] ifm_beats;
    logic [31:0] wgt_base;
    logic [19:0] wgt_beats;
    int          first_cmd;
    int          n_cmd;
  } vec_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_start;
  logic [31:0] cfg_ifm_base;
  logic [19:0] cfg_ifm_beats;
  logic [31:0] cfg_wgt_base;
  logic [19:0] cfg_wgt_beats;
  logic [10:0] ifm_credit;
  logic [10:0] wgt_credit;
  logic        busy;
  logic        done;
  logic        err;

  int   n_vec = 0;
  int   n_err = 0;
  cmd_t sb_q[$];
  cmd_t etab[12];
  vec_t vecs[6];

  axi_rd_burst_scheduler_if #(.ADDR_WIDTH(32)) bus();

  axi_rd_burst_scheduler dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_ifm_base  (cfg_ifm_base),
    .cfg_ifm_beats (cfg_ifm_beats),
    .cfg_wgt_base  (cfg_wgt_base),
    .cfg_wgt_beats (cfg_wgt_beats),
    .ifm_credit    (ifm_credit),
    .wgt_credit    (wgt_credit),
    .cmd_bus       (bus),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_layer(input logic [31:0] ib, input logic [19:0] ibeats,
                             input logic [31:0] wb, input logic [19:0] wbeats);
    cfg_ifm_base  = ib;
    cfg_ifm_beats = ibeats;
    cfg_wgt_base  = wb;
    cfg_wgt_beats = wbeats;
    cfg_start     = 1'b1;
    tick();
    cfg_start     = 1'b0;
  endtask

  // Advance until cmd_valid or done appears; gap counts negedges elapsed.
  task automatic wait_event(inout int gap, output bit got_cmd, output bit got_done,
                            output bit timed_out);
    got_cmd   = 1'b0;
    got_done  = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      gap++;
      if (bus.cmd_valid || done) begin
        got_cmd   = bus.cmd_valid;
        got_done  = done;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic drive_beats(input int n, input bit with_last);
    for (int b = 0; b < n; b++) begin
      bus.rd_beat = 1'b1;
      bus.rd_last = with_last && (b == n - 1);
      tick();
    end
    bus.rd_beat = 1'b0;
    bus.rd_last = 1'b0;
  endtask

  // Accept every command, compare against the scoreboard, return full bursts.
  task automatic serve_layer(input int gap0, input int exp_first_gap);
    int   gap;
    int   exp_gap;
    bit   gc, gd, to;
    cmd_t e;
    gap     = gap0;
    exp_gap = exp_first_gap;
    for (int ev = 0; ev < 20; ev++) begin
      wait_event(gap, gc, gd, to);
      if (to) begin
        check("event_timeout", 64'(1), 64'(0));
        return;
      end
      check("event_latency", 64'(gap), 64'(exp_gap));
      if (gd) begin
        check("done_no_cmd_valid", 64'(bus.cmd_valid), 64'(0));
        check("done_all_cmds_seen", 64'(sb_q.size()), 64'(0));
        return;
      end
      if (sb_q.size() == 0) begin
        check("unexpected_cmd", 64'(bus.cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        e.len = bus.cmd_len;
      end else begin
        e = sb_q.pop_front();
        check("cmd_addr", 64'(bus.cmd_addr), 64'(e.addr));
        check("cmd_len",  64'(bus.cmd_len),  64'(e.len));
        check("cmd_src",  64'(bus.cmd_src),  64'(e.src));
      end
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      check("cmd_valid_dropped", 64'(bus.cmd_valid), 64'(0));
      drive_beats(int'(bus.cmd_len) + 1, 1'b1);
      gap     = 1;
      exp_gap = 2;
    end
    check("layer_too_many_events", 64'(1), 64'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),          64'(0));
    check({tag, "_done"},      64'(done),          64'(0));
    check({tag, "_err"},       64'(err),           64'(0));
    check({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'(0));
    check({tag, "_cmd_addr"},  64'(bus.cmd_addr),  64'(0));
    check({tag, "_cmd_len"},   64'(bus.cmd_len),   64'(0));
    check({tag, "_cmd_src"},   64'(bus.cmd_src),   64'(0));
  endtask

  initial begin
    int          gap;
    bit          gc, gd, to;
    bit          bad;
    logic [31:0] a0;
    logic [7:0]  l0;

    etab[0]  = '{32'h0000_0000, 8'd127, 1'b0};
    etab[1]  = '{32'h0000_1000, 8'd127, 1'b0};
    etab[2]  = '{32'h0002_0000, 8'd127, 1'b1};
    etab[3]  = '{32'h0000_0000, 8'd127, 1'b0};
    etab[4]  = '{32'h0000_0F00, 8'd7,   1'b0};
    etab[5]  = '{32'h0000_1000, 8'd11,  1'b0};
    etab[6]  = '{32'h0000_8FC0, 8'd1,   1'b1};
    etab[7]  = '{32'h0000_3000, 8'd127, 1'b0};
    etab[8]  = '{32'h0000_9000, 8'd7,   1'b1};
    etab[9]  = '{32'h0000_4000, 8'd71,  1'b0};
    etab[10] = '{32'hFFFF_FFE0, 8'd0,   1'b1};
    etab[11] = '{32'h0000_0000, 8'd1,   1'b1};

    vecs[0] = '{32'h0000_0000, 20'd256, 32'h0000_0000, 20'd0,   0,  2};
    vecs[1] = '{32'h0000_0000, 20'd128, 32'h0002_0000, 20'd128, 2,  2};
    vecs[2] = '{32'h0000_0F00, 20'd20,  32'h0000_0000, 20'd0,   4,  2};
    vecs[3] = '{32'h0000_0000, 20'd0,   32'h0000_0000, 20'd0,   6,  0};
    vecs[4] = '{32'h0000_3000, 20'd200, 32'h0000_8FC0, 20'd10,  6,  4};
    vecs[5] = '{32'h0000_0000, 20'd0,   32'hFFFF_FFE0, 20'd3,   10, 2};

    ARESET        = 1'b1;
    cfg_start     = 1'b0;
    cfg_ifm_base  = 32'd0;
    cfg_ifm_beats = 20'd0;
    cfg_wgt_base  = 32'd0;
    cfg_wgt_beats = 20'd0;
    ifm_credit    = 11'd2047;
    wgt_credit    = 11'd2047;
    bus.cmd_ready = 1'b0;
    bus.rd_beat   = 1'b0;
    bus.rd_last   = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    ARESET = 1'b0;
    tick();

    // Table-driven layers.
    for (int i = 0; i < 6; i++) begin
      sb_q.delete();
      for (int c = 0; c < vecs[i].n_cmd; c++) sb_q.push_back(etab[vecs[i].first_cmd + c]);
      start_layer(vecs[i].ifm_base, vecs[i].ifm_beats, vecs[i].wgt_base, vecs[i].wgt_beats);
      serve_layer(1, 2);
      check("layer_err", 64'(err), 64'(0));
      tick();
      check("done_one_cycle", 64'(done), 64'(0));
      check("idle_after_done", 64'(busy), 64'(0));
    end

    // Credit wait: no command until the IFM FIFO can take the whole burst.
    sb_q.delete();
    ifm_credit = 11'd100;
    start_layer(32'h0001_0000, 20'd128, 32'd0, 20'd0);
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.cmd_valid) bad = 1'b1;
    end
    check("credit_wait_no_cmd", 64'(bad), 64'(0));
    check("credit_wait_busy", 64'(busy), 64'(1));
    ifm_credit = 11'd128;
    sb_q.push_back('{32'h0001_0000, 8'd127, 1'b0});
    serve_layer(0, 1);
    ifm_credit = 11'd2047;
    tick();

    // Back-pressure, ignored restart, short burst raises err.
    sb_q.delete();
    start_layer(32'h0000_0100, 20'd8, 32'd0, 20'd0);
    tick();
    check("bp_cmd_valid", 64'(bus.cmd_valid), 64'(1));
    check("bp_cmd_addr", 64'(bus.cmd_addr), 64'h100);
    check("bp_cmd_len", 64'(bus.cmd_len), 64'd7);
    a0  = bus.cmd_addr;
    l0  = bus.cmd_len;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        cfg_ifm_base  = 32'h0000_5000;
        cfg_ifm_beats = 20'd5;
        cfg_wgt_beats = 20'd9;
        cfg_start     = 1'b1;
      end else begin
        cfg_start     = 1'b0;
      end
      tick();
      if (!bus.cmd_valid || bus.cmd_addr !== a0 || bus.cmd_len !== l0 || bus.cmd_src !== 1'b0) bad = 1'b1;
    end
    cfg_start = 1'b0;
    check("bp_cmd_stable", 64'(bad), 64'(0));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    drive_beats(5, 1'b1);
    gap = 1;
    wait_event(gap, gc, gd, to);
    check("short_burst_then_done", 64'(gd), 64'(1));
    check("short_burst_no_cmd", 64'(gc), 64'(0));
    check("short_burst_err", 64'(err), 64'(1));
    tick();
    check("err_sticky", 64'(err), 64'(1));
    check("bp_idle", 64'(busy), 64'(0));

    // Reset in the middle of a burst, then a clean layer.
    sb_q.delete();
    start_layer(32'h0000_0000, 20'd64, 32'd0, 20'd0);
    check("start_clears_err", 64'(err), 64'(0));
    gap = 1;
    wait_event(gap, gc, gd, to);
    check("rst_seq_cmd", 64'(gc), 64'(1));
    check("rst_seq_len", 64'(bus.cmd_len), 64'd63);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    drive_beats(2, 1'b0);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    check_idle_outputs("midburst_reset");
    sb_q.push_back('{32'h0000_0040, 8'd3, 1'b0});
    start_layer(32'h0000_0040, 20'd4, 32'd0, 20'd0);
    serve_layer(1, 2);
    check("post_reset_err", 64'(err), 64'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
